// File: rtl/posit_accum_pkg.sv
// Shared types and constants for the posit sum-reduction sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package posit_accum_pkg;

   // Sequencer phases: pipeline warm-up after reset, accepting input,
   // draining the adder, presenting the packet sum.
   typedef enum logic [1:0] {
      WARM   = 2'd0,
      ACCUM  = 2'd1,
      FLUSH  = 2'd2,
      OUTPUT = 2'd3
   } state_t;

   localparam int POSIT_N       = 8;
   localparam int POSIT_ADD_LAT = 8;

   // Not-a-Real encoding for 8-bit posits.
   localparam logic [7:0] POSIT8_NAR = 8'h80;

endpackage

// File: rtl/posit_accum_seq_8.sv
// Streaming sum-reduction sequencer around an 8-bit posit adder pipeline.
// Latency: 1-element packet out 2 cycles after accept; 2-element packet out ADD_LAT+3 after first accept.
// Backpressure: in_ready low outside ACCUM; output sum held on out_valid until out_ready.
//
// Ports:
//   aclk, reset                       clock, asynchronous active-high reset
//   in_valid/in_data/in_last/in_ready input posit stream, one packet at a time
//   add_in1/add_in2/add_start         operand pair issued to the adder
//   add_result/add_done               sum returning from the adder
//   out_valid/out_data/out_count/out_ready  packet sum and element count
//   err                               sticky: adder result arrived with nothing in flight
module posit_accum_seq_8
   import posit_accum_pkg::*;
#(
   parameter int N       = POSIT_N,
   parameter int ADD_LAT = POSIT_ADD_LAT,
   parameter int CNT_W   = 16
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             in_ready,
   output logic [N-1:0]     add_in1,
   output logic [N-1:0]     add_in2,
   output logic             add_start,
   input  logic [N-1:0]     add_result,
   input  logic             add_done,
   output logic             out_valid,
   output logic [N-1:0]     out_data,
   output logic [CNT_W-1:0] out_count,
   input  logic             out_ready,
   output logic             err
);

   localparam int IF_W = $clog2(ADD_LAT) + 1;
   localparam logic [IF_W-1:0] WARM_LAST = IF_W'(ADD_LAT - 1);

   state_t            state_q, state_d;
   logic [IF_W-1:0]   warm_cnt_q;
   logic [N-1:0]      hold_q, hold_d;
   logic              hold_valid_q, hold_valid_d;
   logic [IF_W-1:0]   inflight_q, inflight_d;
   logic              seen_last_q;
   logic [CNT_W-1:0]  elem_cnt_q;
   logic [N-1:0]      out_data_q;
   logic [CNT_W-1:0]  out_count_q;
   logic              err_q;

   logic active;
   logic accept;
   logic r_vld;
   logic h_vld;
   logic spurious;
   logic done_ok;

   // Operand sources are only live while the reduction is running.
   // The adder is never reset, so its done pulses are ignored during
   // warm-up; outside warm-up a pulse with nothing in flight is stale.
   assign active   = (state_q == ACCUM) || (state_q == FLUSH);
   assign accept   = in_valid && in_ready;
   assign r_vld    = add_done && active && (inflight_q != '0);
   assign spurious = add_done && (state_q != WARM) && (inflight_q == '0);
   assign h_vld    = hold_valid_q && active;

   // A single value left in hold, nothing in the adder and nothing
   // arriving this cycle means the reduction is complete.
   assign done_ok  = (state_q == FLUSH) && seen_last_q && hold_valid_q &&
                     (inflight_q == '0) && !add_done;

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         state_q <= WARM;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // Next state and handshake outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         WARM: begin
            if (warm_cnt_q == WARM_LAST) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (done_ok) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ACCUM;
            end
         end
         default: state_d = WARM;
      endcase
   end

   // ---------------------------------------------------------------
   // Operand selection. With at most three candidates (returned sum,
   // new input, held value) and one issue slot per cycle, hold never
   // needs more than one entry, so input is never stalled in ACCUM.
   // ---------------------------------------------------------------
   always_comb begin
      add_start    = 1'b0;
      add_in1      = '0;
      add_in2      = '0;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      case ({r_vld, accept, h_vld})
         3'b111, 3'b110: begin
            add_start = 1'b1;
            add_in1   = add_result;
            add_in2   = in_data;
         end
         3'b101: begin
            add_start    = 1'b1;
            add_in1      = add_result;
            add_in2      = hold_q;
            hold_valid_d = 1'b0;
         end
         3'b011: begin
            add_start    = 1'b1;
            add_in1      = in_data;
            add_in2      = hold_q;
            hold_valid_d = 1'b0;
         end
         3'b100: begin
            hold_d       = add_result;
            hold_valid_d = 1'b1;
         end
         3'b010: begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
         end
         default: begin
            hold_d       = hold_q;
            hold_valid_d = hold_valid_q;
         end
      endcase
      if (done_ok) begin
         hold_valid_d = 1'b0;
      end
   end

   always_comb begin
      inflight_d = inflight_q;
      case ({add_start, r_vld})
         2'b10:   inflight_d = inflight_q + IF_W'(1);
         2'b01:   inflight_d = inflight_q - IF_W'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath and counters
   // ---------------------------------------------------------------
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         warm_cnt_q   <= '0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         inflight_q   <= '0;
         seen_last_q  <= 1'b0;
         elem_cnt_q   <= '0;
         out_data_q   <= '0;
         out_count_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         if (state_q == WARM) begin
            warm_cnt_q <= warm_cnt_q + IF_W'(1);
         end
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         inflight_q   <= inflight_d;
         if (spurious) begin
            err_q <= 1'b1;
         end
         if (done_ok) begin
            out_data_q  <= hold_q;
            out_count_q <= elem_cnt_q;
            seen_last_q <= 1'b0;
            elem_cnt_q  <= '0;
         end else if (accept) begin
            if (elem_cnt_q != '1) begin
               elem_cnt_q <= elem_cnt_q + CNT_W'(1);
            end
            if (in_last) begin
               seen_last_q <= 1'b1;
            end
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign err       = err_q;

endmodule

// File: tb/tb_posit_accum_seq_8.sv
module tb_posit_accum_seq_8;
   import posit_accum_pkg::*;

   localparam int N   = 8;
   localparam int LAT = 8;
   localparam int CW  = 16;

   logic          aclk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid, in_last, in_ready;
   logic [N-1:0]  in_data;
   logic [N-1:0]  add_in1, add_in2, add_result;
   logic          add_start, add_done;
   logic          out_valid, out_ready, err;
   logic [N-1:0]  out_data;
   logic [CW-1:0] out_count;

   always #5 aclk = ~aclk;

   posit_accum_seq_8 #(.N(N), .ADD_LAT(LAT), .CNT_W(CW)) dut (
      .aclk(aclk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
      .add_result(add_result), .add_done(add_done),
      .out_valid(out_valid), .out_data(out_data), .out_count(out_count),
      .out_ready(out_ready), .err(err)
   );

   // Stand-in adder arithmetic: NaR absorbs, otherwise an associative,
   // commutative rule with 0x40 + 0x40 = 0x42 so that any reduction
   // order gives the same answer as a left-to-right sum.
   function automatic logic [7:0] fadd(input logic [7:0] a, input logic [7:0] b);
      if (a == POSIT8_NAR || b == POSIT8_NAR) return POSIT8_NAR;
      return a + b - 8'h3E;
   endfunction

   // Adder pipeline model: fixed latency, no reset, no stall.
   logic [LAT-1:0] pv = '0;
   logic [N-1:0]   pd [LAT];
   logic           inj_done;
   logic [N-1:0]   inj_data;

   always @(posedge aclk) begin
      pv    <= {pv[LAT-2:0], add_start};
      pd[0] <= fadd(add_in1, add_in2);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end

   assign add_done   = pv[LAT-1] | inj_done;
   assign add_result = inj_done ? inj_data : pd[LAT-1];

   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   typedef struct {
      logic [N-1:0]  d;
      logic [CW-1:0] c;
      int            t;   // expected out_valid rise cycle, -1 = don't care
   } exp_t;
   exp_t sb[$];

   // Adder-side observation: issue count, peak in-flight, last operands.
   int           n_start = 0;
   int           max_pend = 0;
   logic [N-1:0] last_in1, last_in2;
   initial begin
      forever begin
         @(posedge aclk);
         if (add_start) begin
            n_start++;
            last_in1 = add_in1;
            last_in2 = add_in2;
         end
         if ($countones(pv) > max_pend) max_pend = $countones(pv);
      end
   end

   // Output monitor: pops the scoreboard on every output handshake.
   initial begin
      logic prev_v;
      int   rise;
      exp_t e;
      prev_v = 1'b0;
      rise   = 0;
      forever begin
         @(negedge aclk);
         #1;
         if (out_valid && !prev_v) rise = cyc;
         prev_v = out_valid;
         if (out_valid && out_ready && !reset) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("out_data", 32'(out_data), 32'(e.d));
               chk("out_count", 32'(out_count), 32'(e.c));
               if (e.t >= 0) chk("out_latency", 32'(rise), 32'(e.t));
            end
         end
      end
   end

   task automatic push(input logic [N-1:0] d, input logic [CW-1:0] c, input int t);
      exp_t e;
      e.d = d; e.c = c; e.t = t;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge after the accept.
   task automatic send(input logic [N-1:0] d, input logic l, output int acc);
      int g;
      g = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      #1;
      while (!in_ready && g < 100) begin
         @(negedge aclk); #1; g++;
      end
      chk("in_ready_at_send", 32'(in_ready), 32'd1);
      acc = cyc;
      @(negedge aclk);
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 300) begin
         @(negedge aclk); g++;
      end
      chk("drain_scoreboard", 32'(sb.size()), 32'd0);
      repeat (2) @(negedge aclk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready), 0);
      chk({tag, "_add_start"}, 32'(add_start), 0);
      chk({tag, "_add_in1"},   32'(add_in1), 0);
      chk({tag, "_add_in2"},   32'(add_in2), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_out_data"},  32'(out_data), 0);
      chk({tag, "_out_count"}, 32'(out_count), 0);
      chk({tag, "_err"},       32'(err), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: still running at %0t, limit 200000", $time);
      $fatal(1);
   end

   initial begin
      int a, b, s0, first;
      logic [N-1:0] ref_sum;
      in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
      inj_done = 0; inj_data = '0;

      // Reset state
      repeat (3) @(posedge aclk);
      #1 check_reset_outputs("reset");

      // Warm-up: in_ready low exactly LAT cycles with input pending;
      // a stray done pulse during warm-up must not set err.
      @(negedge aclk);
      reset = 1'b0; in_valid = 1'b1; in_data = 8'h40; in_last = 1'b1;
      #1 chk("warm_in_ready_0", 32'(in_ready), 0);
      for (int i = 1; i < LAT; i++) begin
         @(negedge aclk); #1;
         chk("warm_in_ready", 32'(in_ready), 0);
         inj_done = (i == 3); inj_data = 8'h55;
      end
      @(negedge aclk); #1;
      chk("warm_done_in_ready", 32'(in_ready), 1);
      chk("warm_err", 32'(err), 0);
      a = cyc;
      @(negedge aclk);
      in_valid = 1'b0; in_last = 1'b0;
      push(8'h40, 16'd1, a + 2);
      drain();

      // Single element
      send(8'h40, 1'b1, a);
      push(8'h40, 16'd1, a + 2);
      drain();

      // Two elements: one add of 0x40/0x40
      s0 = n_start;
      send(8'h40, 1'b0, a);
      send(8'h40, 1'b1, b);
      push(8'h42, 16'd2, b + 10);
      drain();
      chk("pair_starts", 32'(n_start - s0), 1);
      chk("pair_in1", 32'(last_in1), 32'h40);
      chk("pair_in2", 32'(last_in2), 32'h40);

      // Twenty back-to-back elements
      s0 = n_start; max_pend = 0;
      ref_sum = 8'h40;
      for (int i = 1; i < 20; i++) ref_sum = fadd(ref_sum, 8'h40);
      send(8'h40, 1'b0, first);
      for (int i = 1; i < 20; i++) send(8'h40, (i == 19), a);
      chk("b2b_no_stall", 32'(a - first), 32'd19);
      push(ref_sum, 16'd20, -1);
      drain();
      chk("b2b_starts", 32'(n_start - s0), 19);
      chk("b2b_max_inflight_over", 32'(max_pend > LAT), 0);

      // NaR propagation plus output backpressure
      out_ready = 1'b0;
      send(8'h40, 1'b0, a);
      send(POSIT8_NAR, 1'b0, a);
      send(8'h40, 1'b1, a);
      push(POSIT8_NAR, 16'd3, -1);
      b = 0;
      #1;
      while (!out_valid && b < 100) begin
         @(negedge aclk); #1; b++;
      end
      chk("nar_out_valid", 32'(out_valid), 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk); #1;
         chk("stall_out_valid", 32'(out_valid), 1);
         chk("stall_out_data", 32'(out_data), 32'h80);
         chk("stall_in_ready", 32'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge aclk);
      @(negedge aclk); #1;
      chk("post_handshake_out_valid", 32'(out_valid), 0);
      chk("post_handshake_in_ready", 32'(in_ready), 1);
      drain();

      // Spurious done with nothing in flight: err sticks, hold untouched
      @(negedge aclk);
      inj_done = 1'b1; inj_data = 8'h33;
      @(negedge aclk);
      inj_done = 1'b0;
      #1 chk("spurious_err", 32'(err), 1);
      repeat (3) @(negedge aclk);
      chk("spurious_err_sticky", 32'(err), 1);
      send(8'h40, 1'b1, a);
      push(8'h40, 16'd1, a + 2);
      drain();

      // Reset in the middle of FLUSH, then a clean packet
      send(8'h40, 1'b0, a);
      send(8'h40, 1'b0, a);
      send(8'h40, 1'b1, a);
      reset = 1'b1;
      #1 check_reset_outputs("midflush");
      repeat (2) @(negedge aclk);
      reset = 1'b0;
      send(8'h40, 1'b0, a);
      send(8'h40, 1'b1, b);
      push(8'h42, 16'd2, b + 10);
      drain();
      chk("after_reset_err", 32'(err), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/posit_accum_seq_8.md
Name: posit_accum_seq_8

Overview:
- Streaming sum-reduction sequencer wrapped around the 8-bit posit adder pipeline (posit_adder_8, 8-cycle latency, no reset, no stall).
- Sits directly upstream and downstream of the adder: it accepts a packet of posits, issues operand pairs on add_in1/add_in2/add_start, and recirculates returned add_result values until one value remains.
- The final sum is presented on a valid/ready output.

Parameters:
- N, 8, posit width; must match the adder.
- ADD_LAT, 8, cycles from the add_start cycle to the matching add_done cycle.
- CNT_W, 16, width of the element counter.

Ports:
- aclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input posit valid.
- in_data  in  N  input posit.
- in_last  in  1  marks the final element of the packet.
- in_ready  out  1  input accepted when in_valid&in_ready.
- add_in1  out  N  adder operand 1.
- add_in2  out  N  adder operand 2.
- add_start  out  1  adder issue strobe.
- add_result  in  N  adder sum.
- add_done  in  1  adder result valid.
- out_valid  out  1  packet sum valid.
- out_data  out  N  packet sum.
- out_count  out  CNT_W  number of elements in the packet.
- out_ready  in  1  downstream accepts.
- err  out  1  sticky: add_done received while in-flight count is 0.

Behaviour:
- Reset values: in_ready=0, add_start=0, add_in1/add_in2=0, out_valid=0, out_data=0, out_count=0, err=0. Internal state: state=WARM, hold_valid=0, inflight=0, seen_last=0, elem_cnt=0.
- Reset may occur mid-packet. The adder is not reset, so stale add_done pulses can arrive afterwards.
- WARM: in_ready=0, add_done ignored. A counter counts ADD_LAT cycles, then the block moves to ACCUM. err is not set in WARM.
- ACCUM: in_ready=1.
- Operands each cycle (ACCUM and FLUSH):
  - R = add_done (returned result).
  - I = input accept.
  - H = hold_valid.
- Operand rules:
  - R+I+H → add_start(add_result, in_data); hold unchanged.
  - Exactly two present → add_start on those two. Order is add_result, then in_data, then hold. hold_valid cleared if H was used.
  - Exactly one present → move it into hold; hold_valid=1.
  - None present → idle.
- These rules never need a stall; hold holds at most one value.
- When add_start=0, add_in1/add_in2 are driven to 0.
- inflight counter (width clog2(ADD_LAT)+1):
  - +1 on issue, -1 on a counted add_done; both in the same cycle leaves it unchanged.
  - inflight never exceeds ADD_LAT.
  - add_done with inflight==0 outside WARM: ignored, err set to 1.
- elem_cnt increments on every accept. It saturates at all-ones.
- Accept with in_last sets seen_last and moves the block to FLUSH (in_ready=0).
- Completion in FLUSH requires all of: registered hold_valid=1, inflight==0, add_done=0. When true:
  - out_data<=hold, out_count<=elem_cnt.
  - Clear hold_valid, seen_last and elem_cnt.
  - Move to OUTPUT.
- OUTPUT: out_valid=1, out_data/out_count held stable until out_ready. The handshake cycle returns to ACCUM; out_valid=0 on the next cycle.
- Latency, single-element packet: accepted in cycle t → out_valid in cycle t+2.
- Latency, two-element packet (cycles t, t+1): out_valid in cycle t+ADD_LAT+3.
- Special values (0x00 zero, 0x80 NaR/inf) need no special handling; the adder propagates them.

Decomposition:
- Package posit_accum_pkg:
  - state enum {WARM, ACCUM, FLUSH, OUTPUT}.
  - Default constants POSIT_N=8, POSIT_ADD_LAT=8.
  - Posit constant POSIT8_NAR=8'h80.
- Sub-modules: none. Operand selection and counters are inline.
- Testbench: a behavioural model of the adder (or posit_adder_8 itself) connected at the add_* ports.

Test Plan:
- Reset released, in_valid held 1 → in_ready=0 for exactly 8 cycles, then 1. Stale add_done pulses in WARM leave err=0.
- Single element 0x40 with in_last → out_data=0x40, out_count=1, out_valid 2 cycles after accept.
- Packet 0x40, 0x40 (last) → one add_start with operands 0x40/0x40; out_data=0x42, out_count=2, out_valid at accept_last+10.
- 20 back-to-back 0x40, out_ready=1:
  - in_ready stays 1 until last.
  - inflight never exceeds 8.
  - add_start count is 19; out_count=20.
  - out_data matches the reference-model sequential sum.
- Packet {0x40, 0x80, 0x40} → out_data=0x80. Then hold out_ready=0 for 5 cycles → out_valid and out_data stay stable; in_ready=0 throughout.
- Spurious add_done in ACCUM with inflight=0 → err=1 and stays 1. Assert reset mid-FLUSH → all outputs return to reset values; the next packet sums correctly.
